// File: rtl/nonce_select_pkg.sv
// Shared types and constants for the nonce post-processing stage.
// NUM_NONCES_DEFAULT must stay in step with the miner's nonce count.
package nonce_select_pkg;

  localparam int unsigned NUM_NONCES_DEFAULT = 16;
  localparam int unsigned FOUND_BIT          = 31;
  localparam logic [31:0] BEST_INIT          = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLast,
    StWr0,
    StWr1,
    StDone
  } state_e;

  // First result word: found flag in the top bit, nonce index zero-extended in the low bits.
  function automatic logic [31:0] result_word(input logic found, input logic [7:0] nonce);
    logic [31:0] word;
    word            = {24'd0, nonce};
    word[FOUND_BIT] = found;
    return word;
  endfunction

endpackage

// File: rtl/nonce_min_tracker.sv
// Running minimum of a stream of (index, value) pairs; strict-less update keeps the
// earliest index on ties. next_* expose the post-edge values for same-cycle consumers.
module nonce_min_tracker
  import nonce_select_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      value,
  output logic [IDX_W-1:0] best_idx,
  output logic [31:0]      best_value,
  output logic [IDX_W-1:0] next_idx,
  output logic [31:0]      next_value
);

  always_comb begin
    next_idx   = best_idx;
    next_value = best_value;
    if (clear) begin
      next_idx   = '0;
      next_value = BEST_INIT;
    end else if (valid && (value < best_value)) begin
      next_idx   = idx;
      next_value = value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      best_idx   <= '0;
      best_value <= BEST_INIT;
    end else begin
      best_idx   <= next_idx;
      best_value <= next_value;
    end
  end

endmodule

// File: rtl/nonce_select.sv
// Scans NUM_NONCES hash words from memory, keeps the smallest, compares it with the target
// and writes a two-word result record back over the same single-port bus.
module nonce_select
  import nonce_select_pkg::*;
#(
  parameter int unsigned NUM_NONCES = NUM_NONCES_DEFAULT,
  parameter int unsigned IDX_W      = $clog2(NUM_NONCES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      hash_addr,
  input  logic [15:0]      result_addr,
  input  logic [31:0]      target,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] best_nonce,
  output logic [31:0]      best_hash,
  output logic             mem_clk,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
  logic [15:0]      result_addr_q, result_addr_d;
  logic [31:0]      target_q, target_d;
  logic             found_q, found_d;
  logic             done_q, done_d;
  logic             mem_we_q, mem_we_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic             trk_clear, trk_valid;
  logic [IDX_W-1:0] trk_best_idx, trk_next_idx;
  logic [31:0]      trk_best_value, trk_next_value;

  nonce_min_tracker #(
    .IDX_W(IDX_W)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .clear     (trk_clear),
    .valid     (trk_valid),
    .idx       (cmp_idx_q),
    .value     (mem_read_data),
    .best_idx  (trk_best_idx),
    .best_value(trk_best_value),
    .next_idx  (trk_next_idx),
    .next_value(trk_next_value)
  );

  always_comb begin
    state_d       = state_q;
    rd_idx_d      = rd_idx_q;
    cmp_idx_d     = cmp_idx_q;
    result_addr_d = result_addr_q;
    target_d      = target_q;
    found_d       = found_q;
    done_d        = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    trk_clear     = 1'b0;
    trk_valid     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StRead;
          mem_addr_d    = hash_addr;
          rd_idx_d      = '0;
          cmp_idx_d     = '0;
          found_d       = 1'b0;
          result_addr_d = result_addr;
          target_d      = target;
          trk_clear     = 1'b1;
        end
      end
      StRead: begin
        // Read data lags the address by one cycle, so the first READ cycle has nothing to compare.
        trk_valid = (rd_idx_q != '0);
        if (trk_valid) begin
          cmp_idx_d = cmp_idx_q + 1'b1;
        end
        if (rd_idx_q == LAST_IDX) begin
          state_d = StLast;
        end else begin
          rd_idx_d   = rd_idx_q + 1'b1;
          mem_addr_d = mem_addr_q + 16'd1;
        end
      end
      StLast: begin
        // Final word is folded in here; use the tracker's post-edge values for the record.
        trk_valid   = 1'b1;
        found_d     = (trk_next_value < target_q);
        state_d     = StWr0;
        mem_we_d    = 1'b1;
        mem_addr_d  = result_addr_q;
        mem_wdata_d = result_word(found_d, 8'(trk_next_idx));
      end
      StWr0: begin
        state_d     = StWr1;
        mem_we_d    = 1'b1;
        mem_addr_d  = result_addr_q + 16'd1;
        mem_wdata_d = trk_best_value;
      end
      StWr1: begin
        state_d = StDone;
        done_d  = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      rd_idx_q      <= '0;
      cmp_idx_q     <= '0;
      result_addr_q <= '0;
      target_q      <= '0;
      found_q       <= 1'b0;
      done_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rd_idx_q      <= rd_idx_d;
      cmp_idx_q     <= cmp_idx_d;
      result_addr_q <= result_addr_d;
      target_q      <= target_d;
      found_q       <= found_d;
      done_q        <= done_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign mem_clk        = clk;
  assign done           = done_q;
  assign found          = found_q;
  assign best_nonce     = trk_best_idx;
  assign best_hash      = trk_best_value;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule
